c_fifo_ctrl_mc: RTL
===================

# c_fifo_ctrl_mc

Multi-channel FIFO controller: manages `num_channels` independent circular queues statically partitioned in one shared buffer memory of `num_channels*depth` entries. Accepts one push and one pop per cycle, each to any channel, and produces write and read addresses into the shared memory. Per-channel status (empty, almost-empty, full, almost-full, occupancy) comes from registered occupancy counters. Sits between virtual-channel input logic and the shared flit buffer RAM. It generalises the single-queue FIFO controller to many channels, with occupancy and threshold reporting.

## Interface
- `num_channels`, 4: number of queues (>=1).
- `depth`, 8: entries per queue (>=2).
- `offset`, 0: address of entry 0 of channel 0.
- `almost_full_slack`, 1: `almost_full[c]` when free slots <= slack (0..depth-1).
- `enable_bypass`, 0: allow push+pop to the same empty channel in one cycle.
- Derived: `addr_width = clogb(offset+num_channels*depth)`, `sel_width = max(1, clogb(num_channels))`, `cnt_width = clogb(depth+1)`.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `push_active`  in  1  enables push-side state updates.
- `pop_active`  in  1  enables pop-side state updates.
- `push`  in  1  write one entry to channel `push_sel`.
- `push_sel`  in  sel_width  push channel.
- `pop`  in  1  remove one entry from channel `pop_sel`.
- `pop_sel`  in  sel_width  pop channel.
- `push_addr`  out  addr_width  write address for the current push.
- `pop_addr`  out  addr_width  read address for the current pop.
- `count`  out  num_channels*cnt_width  per-channel occupancy; channel 0 is leftmost.
- `empty`, `almost_empty`, `full`, `almost_full`  out  num_channels each  per-channel status; bit 0 is channel 0.
- `errors`  out  3  [0] underflow, [1] overflow, [2] illegal select.

## Operation
- Per-channel registers: `head[c]`, `tail[c]` (clogb(depth) bits, range 0..depth-1) and `cnt[c]` (0..depth).
- Channel base is `offset + c*depth`.
- `push_addr = base(push_sel) + tail[push_sel]`. `pop_addr = base(pop_sel) + head[pop_sel]`.
- Both addresses are combinational from the selects and registers. They are valid whether or not push/pop is asserted.
- Pointer increment wraps from depth-1 to 0. A pointer never leaves its channel's partition.
- Legal push to c: `tail[c]` increments and `cnt[c]` increments.
- Legal pop from c: `head[c]` increments and `cnt[c]` decrements.
- Simultaneous push and pop, different channels: both proceed independently.
- Simultaneous push and pop, same channel:
  - Both pointers advance and the count is unchanged.
  - Legal when the channel is full: no overflow is flagged.
- Same channel and empty:
  - With `enable_bypass=1`: both pointers advance, `cnt` stays 0, no error. `push_addr == pop_addr`; the datapath forwards the data.
  - Without bypass: this is underflow. The pop is ignored and the push proceeds.
- Underflow: pop to a channel with cnt==0, other than the legal bypass case.
- Overflow: push to a channel with cnt==depth and no same-channel pop in the same cycle.
- Illegal select: `push&(push_sel>=num_channels)` or `pop&(pop_sel>=num_channels)`.
- Any erroneous operation is dropped: its pointers and count are unchanged. The other operation in the cycle still proceeds.
- Push-side updates are gated by `push_active`; pop-side updates by `pop_active`. Push/pop asserted while its active is low is ignored and produces no error.
- `cnt` updates when either active is high, using only the enabled operations.
- Status, per channel c, all decoded from registered `cnt[c]`:
  - `empty = (cnt==0)`
  - `almost_empty = (cnt==1)`
  - `full = (cnt==depth)`
  - `almost_full = (cnt >= depth-almost_full_slack)`
- `errors` is combinational from inputs and current state. Simulation-only `$display` on each error at posedge clk.

## Timing
- Reset (asynchronous assert, synchronous release to clk):
  - All head, tail and cnt are 0.
  - `empty` all ones; `almost_empty`, `full`, `almost_full` all zeros.
  - `count` is 0; `errors` is 0.
  - `push_addr`/`pop_addr` equal base of the current selects.
- Reset mid-operation discards all queue contents immediately.
- Addresses: zero-cycle latency from `push_sel`/`pop_sel`. The memory write uses `push_addr` in the push cycle.
- Status and count reflect an operation in cycle N from cycle N+1. There is no combinational path from push/pop to status.
- Throughput: one push and one pop every cycle, sustained.

## Test plan
- Reset, num_channels=4, depth=4, offset=0:
  - Pulse reset low mid-traffic -> empty=4'b1111, count all 0, push_sel=2 gives push_addr=8.
- Fill and wrap:
  - 4 pushes to ch1 -> push_addr 4,5,6,7, then full[1]=1, almost_full[1]=1 after cycle 3 (slack 1).
  - 4 pops -> pop_addr 4,5,6,7, empty[1]=1.
  - One more push -> push_addr 4 (wrap).
- Overflow/underflow:
  - Push to full ch0 alone -> errors[1]=1, count[0] stays 4.
  - Pop from empty ch3 (bypass=0) -> errors[0]=1, head[3] unchanged.
- Simultaneous ops:
  - Push ch2 + pop ch0 (cnt0=2) -> cnt2+1, cnt0=1, almost_empty[0]=1.
  - Push+pop on full ch0 -> no error, count[0] stays 4.
- Bypass=1:
  - Push+pop on empty ch1 -> push_addr==pop_addr, errors=0, empty[1] stays 1, both pointers advance.
- Illegal select and gating:
  - num_channels=3, push_sel=3 -> errors[2]=1, no state change.
  - push with push_active=0 -> no change, no error.

Source files
------------

// File: rtl/c_fifo_ctrl_mc.sv
// Multi-channel FIFO controller: per-channel circular head/tail/count state for
// num_channels queues statically partitioned in one shared buffer memory.
module c_fifo_ctrl_mc #(
   parameter int num_channels      = 4,
   parameter int depth             = 8,
   parameter int offset            = 0,
   parameter int almost_full_slack = 1,
   parameter bit enable_bypass     = 1'b0,
   localparam int addr_width = $clog2(offset + num_channels*depth),
   localparam int sel_width  = (num_channels > 1) ? $clog2(num_channels) : 1,
   localparam int cnt_width  = $clog2(depth + 1)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              push_active,
   input  logic                              pop_active,
   input  logic                              push,
   input  logic [sel_width-1:0]              push_sel,
   input  logic                              pop,
   input  logic [sel_width-1:0]              pop_sel,
   output logic [addr_width-1:0]             push_addr,
   output logic [addr_width-1:0]             pop_addr,
   output logic [num_channels*cnt_width-1:0] count,
   output logic [num_channels-1:0]           empty,
   output logic [num_channels-1:0]           almost_empty,
   output logic [num_channels-1:0]           full,
   output logic [num_channels-1:0]           almost_full,
   output logic [2:0]                        errors
);

   localparam int ptr_width = $clog2(depth);
   localparam logic [sel_width:0]     num_ch_ext = (sel_width+1)'(num_channels);
   localparam logic [ptr_width-1:0]   ptr_last   = ptr_width'(depth - 1);
   localparam logic [cnt_width-1:0]   cnt_full   = cnt_width'(depth);
   localparam logic [cnt_width-1:0]   af_level   = cnt_width'(depth - almost_full_slack);

   logic [ptr_width-1:0] head_q [num_channels];
   logic [ptr_width-1:0] head_d [num_channels];
   logic [ptr_width-1:0] tail_q [num_channels];
   logic [ptr_width-1:0] tail_d [num_channels];
   logic [cnt_width-1:0] cnt_q  [num_channels];
   logic [cnt_width-1:0] cnt_d  [num_channels];

   logic                 push_in_range, pop_in_range;
   logic [sel_width-1:0] push_idx, pop_idx;
   logic                 push_en, pop_en, push_ok, pop_ok, same_ch;
   logic                 underflow, overflow, illegal, push_do, pop_do;

   function automatic logic [ptr_width-1:0] inc_ptr(input logic [ptr_width-1:0] p);
      return (p == ptr_last) ? '0 : p + ptr_width'(1);
   endfunction

   // Out-of-range selects are steered to channel 0 so array reads stay in bounds.
   assign push_in_range = ({1'b0, push_sel} < num_ch_ext);
   assign pop_in_range  = ({1'b0, pop_sel} < num_ch_ext);
   assign push_idx      = push_in_range ? push_sel : '0;
   assign pop_idx       = pop_in_range  ? pop_sel  : '0;

   assign push_addr = addr_width'(offset) + addr_width'(push_sel) * addr_width'(depth)
                    + addr_width'(tail_q[push_idx]);
   assign pop_addr  = addr_width'(offset) + addr_width'(pop_sel) * addr_width'(depth)
                    + addr_width'(head_q[pop_idx]);

   always_comb begin
      push_en   = push & push_active;
      pop_en    = pop & pop_active;
      push_ok   = push_en & push_in_range;
      pop_ok    = pop_en & pop_in_range;
      same_ch   = push_ok & pop_ok & (push_sel == pop_sel);
      underflow = pop_ok & (cnt_q[pop_idx] == '0) & ~(enable_bypass & same_ch);
      overflow  = push_ok & (cnt_q[push_idx] == cnt_full) & ~same_ch;
      illegal   = (push_en & ~push_in_range) | (pop_en & ~pop_in_range);
      push_do   = push_ok & ~overflow;
      pop_do    = pop_ok & ~underflow;
      errors    = {illegal, overflow, underflow};
   end

   always_comb begin
      // NOTE: every next-state array starts as a copy of the current state so no path leaves it unassigned, which would infer a latch.
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      for (int c = 0; c < num_channels; c++) begin
         logic inc, dec;
         inc = push_do & (push_idx == sel_width'(c));
         dec = pop_do & (pop_idx == sel_width'(c));
         if (inc) tail_d[c] = inc_ptr(tail_q[c]);
         if (dec) head_d[c] = inc_ptr(head_q[c]);
         if (inc && !dec)      cnt_d[c] = cnt_q[c] + cnt_width'(1);
         else if (dec && !inc) cnt_d[c] = cnt_q[c] - cnt_width'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: these arrays are a handful of pointer/count flops and must be reset; the shared data RAM outside carries no reset.
         for (int c = 0; c < num_channels; c++) begin
            head_q[c] <= '0;
            tail_q[c] <= '0;
            cnt_q[c]  <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      count = '0;
      for (int c = 0; c < num_channels; c++) begin
         count[(num_channels-1-c)*cnt_width +: cnt_width] = cnt_q[c];
         empty[c]        = (cnt_q[c] == '0);
         almost_empty[c] = (cnt_q[c] == cnt_width'(1));
         full[c]         = (cnt_q[c] == cnt_full);
         almost_full[c]  = (cnt_q[c] >= af_level);
      end
   end

endmodule
